axi_sram: RTL and testbench

Slave-side memory controller for the debug AXI path: it accepts AXI-lite-style read and write transactions (18-bit word address, 16-bit data) and performs them on an external asynchronous 256K×16 SRAM. It sits directly downstream of the UART debug master and consumes its `ar`, `r`, `aw`, `w` and `b` channels. It executes one SRAM access at a time, with a parameterised access time.

---
 rtl/axi_sram_pkg.sv | 30 +++
 rtl/axi_sram.sv | 192 +++++++++++++++++++
 tb/tb_axi_sram.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types and widths for the debug-AXI SRAM slave.
// The debug-bus widths are shared with the UART debug master.
package axi_sram_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;
   localparam int DBG_AW  = SRAM_AW;
   localparam int DBG_DW  = SRAM_DW;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_RESP,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      WR_RESP
   } sram_state_t;

   function automatic logic is_access(sram_state_t s);
      return (s == RD) || (s == WR_SETUP) ||
             (s == WR_PULSE) || (s == WR_HOLD);
   endfunction

   function automatic logic is_wr_drive(sram_state_t s);
      return (s == WR_SETUP) || (s == WR_PULSE) ||
             (s == WR_HOLD);
   endfunction

endpackage

// File: rtl/axi_sram.sv
// AXI-lite style slave driving an async 256Kx16 SRAM.
// One access at a time; reads and writes alternate when both wait.
module axi_sram
   import axi_sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               axi_resetn,
   input  logic [DBG_AW-1:0]  axi_ar_addr,
   input  logic               axi_ar_valid,
   output logic               axi_ar_ready,
   output logic [DBG_DW-1:0]  axi_r_data,
   output logic               axi_r_valid,
   input  logic               axi_r_ready,
   input  logic [DBG_AW-1:0]  axi_aw_addr,
   input  logic               axi_aw_valid,
   output logic               axi_aw_ready,
   input  logic [DBG_DW-1:0]  axi_w_data,
   input  logic               axi_w_valid,
   output logic               axi_w_ready,
   output logic               axi_b_valid,
   input  logic               axi_b_ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_o,
   input  logic [SRAM_DW-1:0] sram_dq_i,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_lb_n,
   output logic               sram_ub_n
);

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   sram_state_t        r_state;
   sram_state_t        w_nxt;
   logic               r_run;
   logic               r_aw_held;
   logic               r_w_held;
   logic               r_prefer_wr;
   logic [SRAM_AW-1:0] r_aw_addr;
   logic [SRAM_DW-1:0] r_w_data;
   logic [SRAM_AW-1:0] r_addr;
   logic [SRAM_DW-1:0] r_dq_o;
   logic [SRAM_DW-1:0] r_r_data;
   logic               r_r_valid;
   logic               r_b_valid;
   logic               r_ce_n;
   logic               r_oe_n;
   logic               r_we_n;
   logic               r_be_n;
   logic               r_dq_oe;
   logic [3:0]         r_wait;
   logic               w_wr_pend;
   logic               w_ar_hs;
   logic               w_aw_hs;
   logic               w_w_hs;
   logic               w_wr_start;

   // r_run keeps every ready low until the first edge after reset
   assign w_wr_pend    = r_aw_held && r_w_held;
   assign axi_ar_ready = r_run && (r_state == IDLE) &&
                         !(w_wr_pend && r_prefer_wr);
   assign axi_aw_ready = r_run && !r_aw_held;
   assign axi_w_ready  = r_run && !r_w_held;

   assign w_ar_hs    = axi_ar_valid && axi_ar_ready;
   assign w_aw_hs    = axi_aw_valid && axi_aw_ready;
   assign w_w_hs     = axi_w_valid && axi_w_ready;
   assign w_wr_start = (r_state == IDLE) && (w_nxt == WR_SETUP);

   always_ff @(posedge clk or negedge axi_resetn) begin
      if (!axi_resetn) r_state <= IDLE;
      else             r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_ar_hs)        w_nxt = RD;
            else if (w_wr_pend) w_nxt = WR_SETUP;
         end
         RD:       if (r_wait == 4'd0) w_nxt = RD_RESP;
         RD_RESP:  if (axi_r_ready) w_nxt = IDLE;
         WR_SETUP: w_nxt = WR_PULSE;
         WR_PULSE: if (r_wait == 4'd0) w_nxt = WR_HOLD;
         WR_HOLD:  w_nxt = WR_RESP;
         WR_RESP:  if (axi_b_ready) w_nxt = IDLE;
         default:  w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_run       <= 1'b0;
         r_aw_held   <= 1'b0;
         r_w_held    <= 1'b0;
         r_aw_addr   <= '0;
         r_w_data    <= '0;
         r_prefer_wr <= 1'b1;
      end else begin
         r_run <= 1'b1;
         if (w_aw_hs) begin
            r_aw_addr <= axi_aw_addr;
            r_aw_held <= 1'b1;
         end else if (r_state == WR_HOLD) begin
            r_aw_held <= 1'b0;
         end
         if (w_w_hs) begin
            r_w_data <= axi_w_data;
            r_w_held <= 1'b1;
         end else if (r_state == WR_HOLD) begin
            r_w_held <= 1'b0;
         end
         if (w_ar_hs)         r_prefer_wr <= 1'b1;
         else if (w_wr_start) r_prefer_wr <= 1'b0;
      end
   end

   // Address and write data only change when a new access is launched
   always_ff @(posedge clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_addr <= '0;
         r_dq_o <= '0;
         r_wait <= '0;
      end else begin
         if (w_ar_hs) begin
            r_addr <= axi_ar_addr;
         end else if (w_wr_start) begin
            r_addr <= r_aw_addr;
            r_dq_o <= r_w_data;
         end
         if ((w_nxt == RD && r_state != RD) ||
             (w_nxt == WR_PULSE && r_state != WR_PULSE))
            r_wait <= LP_WAIT;
         else if (r_wait != 4'd0)
            r_wait <= r_wait - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_r_data  <= '0;
         r_r_valid <= 1'b0;
         r_b_valid <= 1'b0;
      end else begin
         if (r_state == RD && w_nxt == RD_RESP) begin
            r_r_data  <= sram_dq_i;
            r_r_valid <= 1'b1;
         end else if (r_state == RD_RESP && axi_r_ready) begin
            r_r_valid <= 1'b0;
         end
         if (r_state == WR_HOLD)
            r_b_valid <= 1'b1;
         else if (r_state == WR_RESP && axi_b_ready)
            r_b_valid <= 1'b0;
      end
   end

   // Strobes are registered from the next state so they track it exactly
   always_ff @(posedge clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_be_n  <= 1'b1;
         r_dq_oe <= 1'b0;
      end else begin
         r_ce_n  <= !is_access(w_nxt);
         r_be_n  <= !is_access(w_nxt);
         r_oe_n  <= (w_nxt != RD);
         r_we_n  <= (w_nxt != WR_PULSE);
         r_dq_oe <= is_wr_drive(w_nxt);
      end
   end

   assign axi_r_data  = r_r_data;
   assign axi_r_valid = r_r_valid;
   assign axi_b_valid = r_b_valid;
   assign sram_addr   = r_addr;
   assign sram_dq_o   = r_dq_o;
   assign sram_dq_oe  = r_dq_oe;
   assign sram_ce_n   = r_ce_n;
   assign sram_oe_n   = r_oe_n;
   assign sram_we_n   = r_we_n;
   assign sram_lb_n   = r_be_n;
   assign sram_ub_n   = r_be_n;

endmodule

// File: tb/tb_axi_sram.sv
// Scoreboard bench for axi_sram: three instances with
// WAIT_CYCLES = 1, 0 and 15 share one SRAM model.
module tb_axi_sram;

   logic        clk;
   logic        rst_n;
   logic [17:0] ar_addr [3];
   logic        ar_valid [3];
   logic        ar_ready [3];
   logic [15:0] r_data [3];
   logic        r_valid [3];
   logic        r_ready [3];
   logic [17:0] aw_addr [3];
   logic        aw_valid [3];
   logic        aw_ready [3];
   logic [15:0] w_data [3];
   logic        w_valid [3];
   logic        w_ready [3];
   logic        b_valid [3];
   logic        b_ready [3];
   logic [17:0] addr [3];
   logic [15:0] dq_o [3];
   logic [15:0] dq_i [3];
   logic        dq_oe [3];
   logic        ce_n [3];
   logic        oe_n [3];
   logic        we_n [3];
   logic        lb_n [3];
   logic        ub_n [3];

   logic [15:0] mem [0:262143];

   logic [18:0] exp_acc [$];
   logic [15:0] exp_r [$];
   int          exp_b [$];

   int n_vec = 0;
   int n_err = 0;
   int perr = 0;
   int cyc = 0;

   logic        p_ce [3];
   logic        p_we [3];
   logic        p_dqoe [3];
   logic [17:0] p_addr [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      axi_sram #(
         .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 15))
      ) u_dut (
         .clk          (clk),
         .axi_resetn   (rst_n),
         .axi_ar_addr  (ar_addr[g]),
         .axi_ar_valid (ar_valid[g]),
         .axi_ar_ready (ar_ready[g]),
         .axi_r_data   (r_data[g]),
         .axi_r_valid  (r_valid[g]),
         .axi_r_ready  (r_ready[g]),
         .axi_aw_addr  (aw_addr[g]),
         .axi_aw_valid (aw_valid[g]),
         .axi_aw_ready (aw_ready[g]),
         .axi_w_data   (w_data[g]),
         .axi_w_valid  (w_valid[g]),
         .axi_w_ready  (w_ready[g]),
         .axi_b_valid  (b_valid[g]),
         .axi_b_ready  (b_ready[g]),
         .sram_addr    (addr[g]),
         .sram_dq_o    (dq_o[g]),
         .sram_dq_i    (dq_i[g]),
         .sram_dq_oe   (dq_oe[g]),
         .sram_ce_n    (ce_n[g]),
         .sram_oe_n    (oe_n[g]),
         .sram_we_n    (we_n[g]),
         .sram_lb_n    (lb_n[g]),
         .sram_ub_n    (ub_n[g])
      );
      assign dq_i[g] = (!ce_n[g] && !oe_n[g]) ?
                       mem[addr[g]] : 16'hDEAD;
   end

   function automatic int wc(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // SRAM write model, scoreboard pops and bus protocol checks
   initial begin
      for (int k = 0; k < 3; k++) begin
         p_ce[k] = 1'b1;
         p_we[k] = 1'b1;
         p_dqoe[k] = 1'b0;
         p_addr[k] = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rst_n) begin
               if (!we_n[k] && !ce_n[k]) mem[addr[k]] = dq_o[k];
               if (r_valid[k] && r_ready[k]) begin
                  if (exp_r.size() == 0) chk("r_unexp", 1, 0);
                  else chk("r_data", r_data[k], exp_r.pop_front());
               end
               if (b_valid[k] && b_ready[k]) begin
                  if (exp_b.size() == 0) chk("b_unexp", 1, 0);
                  else chk("b_inst", k, exp_b.pop_front());
               end
               if (!ce_n[k] && p_ce[k]) begin
                  if (exp_acc.size() == 0) chk("acc_unexp", 1, 0);
                  else chk("acc", {dq_oe[k], addr[k]},
                           exp_acc.pop_front());
               end
               if (!we_n[k] && (!dq_oe[k] || !p_dqoe[k])) perr++;
               if (we_n[k] && !p_we[k] && !dq_oe[k]) perr++;
               if (!ce_n[k] && !p_ce[k] && addr[k] != p_addr[k])
                  perr++;
            end
            p_ce[k] = ce_n[k];
            p_we[k] = we_n[k];
            p_dqoe[k] = dq_oe[k];
            p_addr[k] = addr[k];
         end
      end
   end

   task automatic do_read(input int k, input logic [17:0] a,
                          input logic [15:0] d, input int hold);
      int  hs_cyc;
      int  lat;
      int  n_oe;
      int  n_bad;
      bit  ok;
      exp_r.push_back(d);
      exp_acc.push_back({1'b0, a});
      r_ready[k] = (hold == 0);
      ar_addr[k] = a;
      ar_valid[k] = 1'b1;
      ok = 0;
      hs_cyc = 0;
      lat = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (ar_ready[k]) begin
            ok = 1;
            hs_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      ar_valid[k] = 1'b0;
      if (!ok) begin
         chk("ar_timeout", 1, 0);
         return;
      end
      n_oe = 0;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (!oe_n[k]) n_oe++;
         if (r_valid[k]) begin
            ok = 1;
            lat = cyc - hs_cyc;
         end
      end
      if (!ok) begin
         chk("r_timeout", 1, 0);
         r_ready[k] = 1'b1;
         return;
      end
      chk("rd_lat", lat, wc(k) + 2);
      chk("oe_width", n_oe, wc(k) + 1);
      if (hold > 0) begin
         n_bad = 0;
         for (int i = 0; i < hold; i++) begin
            if (!r_valid[k] || r_data[k] !== d || ar_ready[k])
               n_bad++;
            @(negedge clk);
         end
         chk("r_bp_stable", n_bad, 0);
         @(posedge clk);
         #1;
         r_ready[k] = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int k, input logic [17:0] a,
                           input logic [15:0] d, input int gap,
                           input int hold);
      int          hs_cyc;
      int          lat;
      int          n_we;
      int          n_bad;
      bit          ok;
      logic [17:0] seen_a;
      logic [15:0] seen_d;
      exp_acc.push_back({1'b1, a});
      exp_b.push_back(k);
      b_ready[k] = (hold == 0);
      aw_addr[k] = a;
      aw_valid[k] = 1'b1;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (aw_ready[k]) ok = 1;
         @(posedge clk);
         #1;
      end
      aw_valid[k] = 1'b0;
      if (!ok) chk("aw_timeout", 1, 0);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      w_data[k] = d;
      w_valid[k] = 1'b1;
      ok = 0;
      hs_cyc = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (w_ready[k]) begin
            ok = 1;
            hs_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      w_valid[k] = 1'b0;
      if (!ok) chk("w_timeout", 1, 0);
      n_we = 0;
      ok = 0;
      lat = 0;
      seen_a = '0;
      seen_d = '0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (!we_n[k]) begin
            if (n_we == 0) begin
               seen_a = addr[k];
               seen_d = dq_o[k];
            end
            n_we++;
         end
         if (b_valid[k]) begin
            ok = 1;
            lat = cyc - hs_cyc;
         end
      end
      if (!ok) begin
         chk("b_timeout", 1, 0);
         b_ready[k] = 1'b1;
         return;
      end
      chk("wr_lat", lat, wc(k) + 5);
      chk("we_width", n_we, wc(k) + 1);
      chk("wr_addr", seen_a, a);
      chk("wr_data", seen_d, d);
      if (hold > 0) begin
         n_bad = 0;
         for (int i = 0; i < hold; i++) begin
            if (!b_valid[k] || ar_ready[k]) n_bad++;
            @(negedge clk);
         end
         chk("b_bp_stable", n_bad, 0);
         @(posedge clk);
         #1;
         b_ready[k] = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic collide(input logic [17:0] wa,
                          input logic [15:0] wd,
                          input logic [17:0] ra,
                          input logic [15:0] rd,
                          input bit write_first);
      bit arhs;
      bit r_seen;
      bit b_seen;
      int r_cyc;
      int b_cyc;
      if (write_first) begin
         exp_acc.push_back({1'b1, wa});
         exp_acc.push_back({1'b0, ra});
      end else begin
         exp_acc.push_back({1'b0, ra});
         exp_acc.push_back({1'b1, wa});
      end
      exp_r.push_back(rd);
      exp_b.push_back(0);
      r_ready[0] = 1'b1;
      b_ready[0] = 1'b1;
      aw_addr[0] = wa;
      w_data[0] = wd;
      aw_valid[0] = 1'b1;
      w_valid[0] = 1'b1;
      @(negedge clk);
      chk("col_accept", {aw_ready[0], w_ready[0]}, 2'b11);
      @(posedge clk);
      #1;
      aw_valid[0] = 1'b0;
      w_valid[0] = 1'b0;
      ar_addr[0] = ra;
      ar_valid[0] = 1'b1;
      arhs = 0;
      r_seen = 0;
      b_seen = 0;
      r_cyc = 0;
      b_cyc = 0;
      for (int i = 0; i < 100 && !(arhs && r_seen && b_seen); i++) begin
         @(negedge clk);
         if (i == 0) chk("col_arready", ar_ready[0], !write_first);
         if (ar_valid[0] && ar_ready[0]) arhs = 1;
         if (r_valid[0] && !r_seen) begin
            r_seen = 1;
            r_cyc = cyc;
         end
         if (b_valid[0] && !b_seen) begin
            b_seen = 1;
            b_cyc = cyc;
         end
         @(posedge clk);
         #1;
         if (arhs) ar_valid[0] = 1'b0;
      end
      ar_valid[0] = 1'b0;
      if (!(arhs && r_seen && b_seen)) chk("col_timeout", 1, 0);
      else chk("col_order", (b_cyc < r_cyc), write_first);
   endtask

   initial begin
      int nb;
      bit ok;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ar_addr[k] = '0;
         ar_valid[k] = 1'b0;
         r_ready[k] = 1'b1;
         aw_addr[k] = '0;
         aw_valid[k] = 1'b0;
         w_data[k] = '0;
         w_valid[k] = 1'b0;
         b_ready[k] = 1'b1;
      end
      mem[18'h00ABC] = 16'h1234;
      mem[18'h00020] = 16'hA5A5;
      mem[18'h00100] = 16'h0101;
      mem[18'h00300] = 16'h0303;

      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_strobes",
             {ce_n[k], oe_n[k], we_n[k], lb_n[k], ub_n[k]}, 5'h1F);
         chk("rst_readies", {ar_ready[k], aw_ready[k], w_ready[k]}, 0);
         chk("rst_valids", {r_valid[k], b_valid[k], dq_oe[k]}, 0);
      end
      chk("rst_addr", addr[0], 0);
      chk("rst_dq_o", dq_o[0], 0);
      chk("rst_r_data", r_data[0], 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk("idle_readies",
             {ar_ready[k], aw_ready[k], w_ready[k]}, 3'b111);
      @(posedge clk);
      #1;

      do_read(0, 18'h00ABC, 16'h1234, 0);
      do_write(0, 18'h3FFFF, 16'hBEEF, 5, 0);
      do_read(0, 18'h3FFFF, 16'hBEEF, 0);

      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      collide(18'h00010, 16'h5555, 18'h00020, 16'hA5A5, 1'b1);
      do_write(0, 18'h00030, 16'h0F0F, 0, 0);
      collide(18'h00011, 16'h6666, 18'h00010, 16'h5555, 1'b0);

      do_read(0, 18'h00011, 16'h6666, 10);
      do_write(0, 18'h00040, 16'h4444, 1, 10);
      do_read(0, 18'h00040, 16'h4444, 0);

      do_read(1, 18'h00100, 16'h0101, 0);
      do_write(1, 18'h00200, 16'hCAFE, 1, 0);
      do_read(1, 18'h00200, 16'hCAFE, 0);
      do_read(2, 18'h00300, 16'h0303, 0);
      do_write(2, 18'h00301, 16'hF00D, 0, 0);
      do_read(2, 18'h00301, 16'hF00D, 0);

      exp_acc.push_back({1'b1, 18'h00050});
      aw_addr[0] = 18'h00050;
      w_data[0] = 16'h9999;
      aw_valid[0] = 1'b1;
      w_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      aw_valid[0] = 1'b0;
      w_valid[0] = 1'b0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (!we_n[0]) ok = 1;
      end
      if (!ok) chk("rstw_timeout", 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw_we_n", we_n[0], 1);
      chk("rstw_ce_n", ce_n[0], 1);
      chk("rstw_dq_oe", dq_oe[0], 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rstw_readies",
          {ar_ready[0], aw_ready[0], w_ready[0]}, 3'b111);
      nb = 0;
      repeat (10) begin
         @(negedge clk);
         if (b_valid[0]) nb++;
      end
      chk("rstw_no_b", nb, 0);

      chk("proto", perr, 0);
      chk("sb_acc_left", exp_acc.size(), 0);
      chk("sb_r_left", exp_r.size(), 0);
      chk("sb_b_left", exp_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
